// File: rtl/feeder_pkg.sv
// Shared definitions for the sample feeder: send FSM encoding, default
// geometry and bank-select constants.
package feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } feeder_state_t;

  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_NUM_FEATURES = 7;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Pointer width able to index n words (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// One sample buffer: NUM_FEATURES words of DATA_WIDTH with a write port,
// an asynchronous read port and a full flag. The full flag is set when the
// last word is written and cleared when the reader releases the bank.
// Storage is not reset; only the full flag is.
module feeder_bank
  import feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_FEATURES = DEFAULT_NUM_FEATURES,
  localparam int PTR_W       = ptr_width(NUM_FEATURES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  release_bank,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [NUM_FEATURES];

  // Word storage, written on every accepted host word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

  // Full flag: set by the final write, cleared by the final transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (wr_en && wr_last) begin
      full <= 1'b1;
    end else if (release_bank) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/sample_feeder.sv
// Double-buffered sample feeder. The host fills banks A/B alternately; the
// send FSM streams one full bank at a time to the network and then waits
// for a rising edge on net_done before moving to the other bank, so only
// one sample is ever in flight.
// Optional watchdog: define FEEDER_TIMEOUT_EN to abort WAIT_DONE after
// TIMEOUT_CYCLES cycles and raise the sticky timeout_err.
module sample_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_FEATURES   = DEFAULT_NUM_FEATURES,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] axis_out_data,
  output logic                  axis_out_valid,
  input  logic                  axis_out_ready,
  input  logic                  net_done,
  output logic                  busy,
  output logic [31:0]           sample_count,
  output logic                  timeout_err
);

  localparam int PTR_W = ptr_width(NUM_FEATURES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_FEATURES - 1);

  feeder_state_t state;
  logic                  fill_sel;
  logic                  send_sel;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_addr;
  logic                  net_done_q;
  logic                  full_a;
  logic                  full_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic [DATA_WIDTH-1:0] send_data;
  logic                  send_full;
  logic                  wr_fire;
  logic                  wr_last;
  logic                  send_fire;
  logic                  send_last;
  logic                  net_done_rise;

  assign wr_ready      = (fill_sel == BANK_A) ? !full_a : !full_b;
  assign wr_fire       = wr_valid && wr_ready;
  assign wr_last       = (wr_ptr == LAST_IDX);
  assign send_fire     = (state == ST_SEND) && axis_out_valid && axis_out_ready;
  assign send_last     = send_fire && (rd_ptr == LAST_IDX);
  assign send_full     = (send_sel == BANK_A) ? full_a : full_b;
  assign send_data     = (send_sel == BANK_A) ? rd_data_a : rd_data_b;
  assign net_done_rise = net_done && !net_done_q;

  // In IDLE the read port looks at word 0 so it can be loaded on entry to
  // SEND; in SEND it looks one word ahead so the next word is ready to load
  // on each transfer.
  assign rd_addr = ((state == ST_SEND) && (rd_ptr != LAST_IDX)) ? rd_ptr + 1'b1 : '0;

  feeder_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_FEATURES(NUM_FEATURES)
  ) u_bank_a (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_fire && (fill_sel == BANK_A)),
    .wr_addr     (wr_ptr),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data_a),
    .release_bank(send_last && (send_sel == BANK_A)),
    .full        (full_a)
  );

  feeder_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_FEATURES(NUM_FEATURES)
  ) u_bank_b (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_fire && (fill_sel == BANK_B)),
    .wr_addr     (wr_ptr),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data_b),
    .release_bank(send_last && (send_sel == BANK_B)),
    .full        (full_b)
  );

  // Fill side: advance the write pointer and swap banks after the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_sel <= BANK_A;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_ptr   <= '0;
        fill_sel <= ~fill_sel;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Delayed net_done for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_done_q <= 1'b0;
    end else begin
      net_done_q <= net_done;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer;
  logic             timeout_flag;

  assign timeout_err = timeout_flag;
`else
  assign timeout_err = 1'b0;
`endif

  // Send FSM with registered stream outputs, busy and completion count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      rd_ptr         <= '0;
      send_sel       <= BANK_A;
      axis_out_valid <= 1'b0;
      axis_out_data  <= '0;
      busy           <= 1'b0;
      sample_count   <= '0;
`ifdef FEEDER_TIMEOUT_EN
      timer          <= '0;
      timeout_flag   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (send_full) begin
            state          <= ST_SEND;
            rd_ptr         <= '0;
            axis_out_valid <= 1'b1;
            axis_out_data  <= send_data;
            busy           <= 1'b1;
          end
        end
        ST_SEND: begin
          if (send_fire) begin
            if (rd_ptr == LAST_IDX) begin
              state          <= ST_WAIT_DONE;
              rd_ptr         <= '0;
              axis_out_valid <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
              timer          <= TMR_LOAD;
`endif
            end else begin
              rd_ptr        <= rd_ptr + 1'b1;
              axis_out_data <= send_data;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (net_done_rise) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            send_sel     <= ~send_sel;
            sample_count <= sample_count + 32'd1;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (timer == '0) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            send_sel     <= ~send_sel;
            timeout_flag <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: streaming order, backpressure, bank
// exhaustion, mid-sample reset, net_done edge handling and the watchdog.
module tb_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] axis_out_data;
  logic        axis_out_valid;
  logic        axis_out_ready;
  logic        net_done;
  logic        busy;
  logic [31:0] sample_count;
  logic        timeout_err;

  int tests  = 0;
  int failed = 0;

  logic [15:0] got [$];
  logic        mon_prev_stall = 1'b0;
  logic [15:0] mon_prev_data  = '0;

  sample_feeder #(
    .DATA_WIDTH    (16),
    .NUM_FEATURES  (7),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .axis_out_data (axis_out_data),
    .axis_out_valid(axis_out_valid),
    .axis_out_ready(axis_out_ready),
    .net_done      (net_done),
    .busy          (busy),
    .sample_count  (sample_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record transfers and check that stalled data is held.
  always @(negedge clk) begin
    #1;
    if (mon_prev_stall && axis_out_valid) begin
      chk("stall_hold", {16'd0, axis_out_data}, {16'd0, mon_prev_data});
    end
    mon_prev_stall = axis_out_valid && !axis_out_ready && !rst;
    mon_prev_data  = axis_out_data;
    if (axis_out_valid && axis_out_ready) got.push_back(axis_out_data);
  end

  // Call at a negedge; returns at the negedge after the word is accepted.
  task automatic write_word(input logic [15:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (wr_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("wr_accept_timeout", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic write_sample(input logic [15:0] base);
    for (int i = 0; i < 7; i++) write_word(base + 16'(i));
    wr_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string tag);
    for (int c = 0; c < 300; c++) begin
      if (got.size() >= n) break;
      @(negedge clk);
      #2;
    end
    chk(tag, got.size(), n);
  endtask

  task automatic check_got(input logic [15:0] base, input int offset, input string tag);
    for (int i = 0; i < 7; i++) begin
      if (offset + i < got.size())
        chk($sformatf("%s_w%0d", tag, i), {16'd0, got[offset + i]}, {16'd0, base + 16'(i)});
      else
        chk($sformatf("%s_missing%0d", tag, i), got.size(), offset + i + 1);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst            = 1'b1;
    wr_data        = '0;
    wr_valid       = 1'b0;
    axis_out_ready = 1'b1;
    net_done       = 1'b0;

    // Reset state
    #1;
    chk("rst_valid", {31'd0, axis_out_valid}, 32'd0);
    chk("rst_data",  {16'd0, axis_out_data}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_count", sample_count, 32'd0);
    chk("rst_terr",  {31'd0, timeout_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

    // Basic stream, ready held high, latency and completion
    write_sample(16'd1);
    chk("lat_valid_early", {31'd0, axis_out_valid}, 32'd0);
    @(negedge clk);
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("t26_valid%0d", i), {31'd0, axis_out_valid}, 32'd1);
      chk($sformatf("t26_data%0d", i), {16'd0, axis_out_data}, i);
      @(negedge clk);
    end
    chk("t26_valid_off", {31'd0, axis_out_valid}, 32'd0);
    chk("t26_busy_wait", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    chk("t26_busy_pre", {31'd0, busy}, 32'd1);
    chk("t26_count_pre", sample_count, 32'd0);
    pulse_done();
    chk("t26_busy_post", {31'd0, busy}, 32'd0);
    chk("t26_count", sample_count, 32'd1);

    // Backpressure: ready toggles each cycle
    got.delete();
    axis_out_ready = 1'b0;
    write_sample(16'd1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      axis_out_ready = ~axis_out_ready;
      #2;
      if (got.size() >= 7) break;
    end
    chk("t27_count_xfers", got.size(), 7);
    check_got(16'd1, 0, "t27");
    @(negedge clk);
    axis_out_ready = 1'b1;
    chk("t27_busy", {31'd0, busy}, 32'd1);
    pulse_done();
    chk("t27_count", sample_count, 32'd2);

    // Three samples back to back, net_done withheld
    got.delete();
    write_sample(16'd21);
    write_sample(16'd31);
    write_sample(16'd41);
    chk("t28_ready_full", {31'd0, wr_ready}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t28_ready_hold", {31'd0, wr_ready}, 32'd0);
    chk("t28_one_in_flight", {31'd0, axis_out_valid}, 32'd0);
    chk("t28_sent1", got.size(), 7);
    check_got(16'd21, 0, "t28_s1");
    pulse_done();
    chk("t28_count1", sample_count, 32'd3);
    wait_got(14, "t28_sent2");
    @(negedge clk);
    chk("t28_ready_release", {31'd0, wr_ready}, 32'd1);
    check_got(16'd31, 7, "t28_s2");
    pulse_done();
    chk("t28_count2", sample_count, 32'd4);
    wait_got(21, "t28_sent3");
    check_got(16'd41, 14, "t28_s3");
    pulse_done();
    chk("t28_count3", sample_count, 32'd5);

    // Reset after four words of a sample have transferred
    got.delete();
    write_sample(16'd51);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t29_valid", {31'd0, axis_out_valid}, 32'd0);
    chk("t29_data",  {16'd0, axis_out_data}, 32'd0);
    chk("t29_busy",  {31'd0, busy}, 32'd0);
    chk("t29_count", sample_count, 32'd0);
    chk("t29_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    @(negedge clk);
    write_sample(16'd10);
    wait_got(7, "t29_sent");
    check_got(16'd10, 0, "t29_new");
    pulse_done();
    chk("t29_count_after", sample_count, 32'd1);

    // net_done held high through the sample needs a fresh edge
    got.delete();
    net_done = 1'b1;
    @(negedge clk);
    write_sample(16'd61);
    wait_got(7, "t31_sent");
    repeat (5) @(negedge clk);
    chk("t31_busy_high", {31'd0, busy}, 32'd1);
    chk("t31_count_hold", sample_count, 32'd1);
    net_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("t31_busy_low", {31'd0, busy}, 32'd1);
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
    chk("t31_busy_done", {31'd0, busy}, 32'd0);
    chk("t31_count", sample_count, 32'd2);
    check_got(16'd61, 0, "t31");

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog expiry after 64 WAIT_DONE cycles
    got.delete();
    @(negedge clk);
    write_sample(16'd71);
    wait_got(7, "t30_sent");
    @(negedge clk);
    repeat (63) @(negedge clk);
    chk("t30_terr_early", {31'd0, timeout_err}, 32'd0);
    chk("t30_busy_early", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t30_terr", {31'd0, timeout_err}, 32'd1);
    chk("t30_busy", {31'd0, busy}, 32'd0);
    chk("t30_count", sample_count, 32'd2);
    got.delete();
    write_sample(16'd81);
    wait_got(7, "t30_next_sent");
    check_got(16'd81, 0, "t30_next");
    pulse_done();
    chk("t30_count_next", sample_count, 32'd3);
    chk("t30_terr_sticky", {31'd0, timeout_err}, 32'd1);
`else
    // Without the watchdog WAIT_DONE waits indefinitely
    got.delete();
    @(negedge clk);
    write_sample(16'd71);
    wait_got(7, "nowd_sent");
    repeat (100) @(negedge clk);
    chk("nowd_busy", {31'd0, busy}, 32'd1);
    chk("nowd_terr", {31'd0, timeout_err}, 32'd0);
    pulse_done();
    chk("nowd_busy_done", {31'd0, busy}, 32'd0);
    chk("nowd_count", sample_count, 32'd3);
    check_got(16'd71, 0, "nowd");
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
